// File: rtl/rr_grant_sequencer_if.sv
// ----------------------------------------------------------------------------
// rr_grant_sequencer_if
// Purpose : grant handshake between rr_grant_sequencer (producer) and its
//           consumer. A grant is transferred when o__grant__valid and
//           i__grant__ready are both high on a rising clock edge.
// Signals : o__grant__valid  grant present (driven by the arbiter)
//           o__grant__id     granted port id (driven by the arbiter)
//           i__grant__ready  consumer accepts the grant this cycle
// Modports: master - arbiter side, slave - consumer side
// ----------------------------------------------------------------------------
interface rr_grant_sequencer_if #(
    parameter int unsigned ID_WIDTH = 3
) ();
    logic                o__grant__valid;
    logic [ID_WIDTH-1:0] o__grant__id;
    logic                i__grant__ready;

    modport master (
        output o__grant__valid,
        output o__grant__id,
        input  i__grant__ready
    );

    modport slave (
        input  o__grant__valid,
        input  o__grant__id,
        output i__grant__ready
    );
endinterface

// File: rtl/rr_grant_sequencer.sv
// ----------------------------------------------------------------------------
// rr_grant_sequencer
// Purpose : round-robin arbiter over NUM_PORTS level-sensitive request lines.
//           Issues one registered grant (port id) per valid/ready handshake.
//           The priority pointer wraps at a runtime limit
//           lim = min(i__max_port, NUM_PORTS-1); requests above lim are ignored.
// Build option:
//           RR_BURST_EN - when defined, adds the BURST_WIDTH parameter, the
//           i__burst_max port and a burst counter that lets the granted port
//           win up to i__burst_max extra consecutive grants while it keeps
//           requesting. Undefined: pure round-robin.
// Ports   : clk          clock, all state on posedge
//           reset        asynchronous, active-low
//           i__max_port  highest participating port / pointer wrap point
//           i__burst_max extra consecutive grants per port (RR_BURST_EN only)
//           i__req       per-port request
//           grant_if     grant handshake (master modport)
//           o__ptr       current priority pointer (status)
// ----------------------------------------------------------------------------
module rr_grant_sequencer #(
    parameter int unsigned NUM_PORTS   = 8,
    parameter int unsigned ID_WIDTH    = 3
`ifdef RR_BURST_EN
    ,
    parameter int unsigned BURST_WIDTH = 3
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ID_WIDTH-1:0]    i__max_port,
`ifdef RR_BURST_EN
    input  logic [BURST_WIDTH-1:0] i__burst_max,
`endif
    input  logic [NUM_PORTS-1:0]   i__req,
    rr_grant_sequencer_if.master   grant_if,
    output logic [ID_WIDTH-1:0]    o__ptr
);

    localparam logic [ID_WIDTH-1:0] LAST_PORT = ID_WIDTH'(NUM_PORTS - 1);

    // Registered state
    logic                 r_valid;
    logic [ID_WIDTH-1:0]  r_id;
    logic [ID_WIDTH-1:0]  r_ptr;

    // Combinational arbitration signals
    logic                 w_hs;
    logic                 w_load;
    logic [ID_WIDTH-1:0]  w_lim;
    logic [ID_WIDTH-1:0]  w_ptr_next;
    logic [ID_WIDTH-1:0]  w_start;
    logic [NUM_PORTS-1:0] w_req_masked;
    logic                 w_any;
    logic                 w_found_hi;
    logic                 w_found_lo;
    logic [ID_WIDTH-1:0]  w_win_hi;
    logic [ID_WIDTH-1:0]  w_win_lo;
    logic [ID_WIDTH-1:0]  w_winner;

`ifdef RR_BURST_EN
    logic [BURST_WIDTH-1:0] r_bc;
    logic [BURST_WIDTH-1:0] w_bc_next;
    logic                   w_stay;
`endif

    // Pointer advance: past the wrap point goes back to port 0.
    function automatic logic [ID_WIDTH-1:0] f_wrap(
        input logic [ID_WIDTH-1:0] x,
        input logic [ID_WIDTH-1:0] lim
    );
        return (x >= lim) ? '0 : x + ID_WIDTH'(1);
    endfunction

    assign w_lim  = (i__max_port > LAST_PORT) ? LAST_PORT : i__max_port;
    assign w_hs   = r_valid & grant_if.i__grant__ready;
    assign w_load = ~r_valid | grant_if.i__grant__ready;

`ifdef RR_BURST_EN
    // Keep favouring the current port while it still requests and its
    // burst allowance is not used up.
    assign w_stay = (r_bc != i__burst_max) && i__req[r_id];
`endif

    // Next pointer; only a handshake moves it.
    always_comb begin
        w_ptr_next = r_ptr;
`ifdef RR_BURST_EN
        w_bc_next  = r_bc;
        if (w_hs) begin
            if (w_stay) begin
                w_ptr_next = r_id;
                w_bc_next  = r_bc + BURST_WIDTH'(1);
            end else begin
                w_ptr_next = f_wrap(r_id, w_lim);
                w_bc_next  = '0;
            end
        end
`else
        if (w_hs) begin
            w_ptr_next = f_wrap(r_id, w_lim);
        end
`endif
    end

    // A pointer left above a lowered limit restarts the scan at port 0.
    assign w_start = (w_ptr_next > w_lim) ? '0 : w_ptr_next;

    always_comb begin
        w_req_masked = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_req_masked[k] = i__req[k] && (ID_WIDTH'(k) <= w_lim);
        end
    end

    // Rotating priority split into two ascending scans: the first request at
    // or above the start point wins; otherwise the first one below it.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (w_req_masked[k]) begin
                if (ID_WIDTH'(k) >= w_start) begin
                    if (!w_found_hi) begin
                        w_found_hi = 1'b1;
                        w_win_hi   = ID_WIDTH'(k);
                    end
                end else begin
                    if (!w_found_lo) begin
                        w_found_lo = 1'b1;
                        w_win_lo   = ID_WIDTH'(k);
                    end
                end
            end
        end
    end

    assign w_any    = |w_req_masked;
    assign w_winner = w_found_hi ? w_win_hi : w_win_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
`ifdef RR_BURST_EN
            r_bc    <= '0;
`endif
        end else begin
            r_ptr <= w_ptr_next;
`ifdef RR_BURST_EN
            r_bc  <= w_bc_next;
`endif
            if (w_load) begin
                r_valid <= w_any;
                if (w_any) begin
                    r_id <= w_winner;
`ifdef RR_BURST_EN
                    // Switching to another port starts a fresh burst.
                    if (w_winner != r_id) begin
                        r_bc <= '0;
                    end
`endif
                end
            end
        end
    end

    assign grant_if.o__grant__valid = r_valid;
    assign grant_if.o__grant__id    = r_id;
    assign o__ptr                   = r_ptr;

    // A held grant must not change or drop before it is accepted.
    a_grant_held: assert property (
        @(posedge clk) disable iff (!reset)
        (r_valid && !grant_if.i__grant__ready) |=> (r_valid && $stable(r_id))
    );

    a_id_range: assert property (
        @(posedge clk) disable iff (!reset)
        r_valid |-> (r_id <= LAST_PORT)
    );

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rr_grant_sequencer
// Drives directed and random request/ready traffic into rr_grant_sequencer.
// A reference model on posedge predicts valid/id/ptr after each edge and
// queues it; a monitor on negedge pops and compares against the outputs.
// Honours RR_BURST_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_rr_grant_sequencer;

    localparam int N   = 8;
    localparam int IDW = 3;
`ifdef RR_BURST_EN
    localparam int BW  = 3;
`endif

    logic           clk      = 1'b0;
    logic           reset    = 1'b0;
    logic [IDW-1:0] max_port = 3'd7;
    logic [N-1:0]   req      = '0;
    logic [IDW-1:0] ptr;
`ifdef RR_BURST_EN
    logic [BW-1:0]  burst_max = '0;
`endif

    rr_grant_sequencer_if #(.ID_WIDTH(IDW)) gif ();

    rr_grant_sequencer #(
        .NUM_PORTS   (N),
        .ID_WIDTH    (IDW)
`ifdef RR_BURST_EN
        ,
        .BURST_WIDTH (BW)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i__max_port  (max_port),
`ifdef RR_BURST_EN
        .i__burst_max (burst_max),
`endif
        .i__req       (req),
        .grant_if     (gif),
        .o__ptr       (ptr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
        logic [IDW-1:0] ptr;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    bit m_v;
    int m_id, m_ptr, m_bc;

    always @(posedge clk) begin : model
        int lim, pn, bn, st, win, k;
        bit hs, found;
        if (!reset) begin
            m_v = 0; m_id = 0; m_ptr = 0; m_bc = 0;
        end else begin
            lim = (int'(max_port) > N - 1) ? N - 1 : int'(max_port);
            hs  = m_v && gif.i__grant__ready;
            pn  = m_ptr;
            bn  = m_bc;
            if (hs) begin
                pn = (m_id >= lim) ? 0 : m_id + 1;
                bn = 0;
`ifdef RR_BURST_EN
                if (m_bc != int'(burst_max) && req[m_id]) begin
                    pn = m_id;
                    bn = (m_bc + 1) % (1 << BW);
                end
`endif
            end
            st = (pn > lim) ? 0 : pn;
            if (!m_v || gif.i__grant__ready) begin
                found = 0;
                win   = 0;
                for (int off = 0; off <= lim; off++) begin
                    k = (st + off) % (lim + 1);
                    if (!found && req[k]) begin
                        found = 1;
                        win   = k;
                    end
                end
                if (found) begin
                    if (win != m_id) bn = 0;
                    m_id = win;
                end
                m_v = found;
            end
            m_ptr = pn;
            m_bc  = bn;
            sb.push_back(exp_t'{m_v, IDW'(m_id), IDW'(m_ptr)});
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow t=%0t: output present but no expectation queued", $time);
            end else begin
                e = sb.pop_front();
                if (gif.o__grant__valid !== e.v || gif.o__grant__id !== e.id || ptr !== e.ptr) begin
                    n_fail++;
                    $display("FAIL grant t=%0t: got v=%0b id=%0d ptr=%0d, expected v=%0b id=%0d ptr=%0d",
                             $time, gif.o__grant__valid, gif.o__grant__id, ptr, e.v, e.id, e.ptr);
                end
            end
        end
    end

    task automatic check_reset(input string name);
        n_tests++;
        if (gif.o__grant__valid !== 1'b0 || gif.o__grant__id !== '0 || ptr !== '0) begin
            n_fail++;
            $display("FAIL %s t=%0t: got v=%0b id=%0d ptr=%0d, expected v=0 id=0 ptr=0",
                     name, $time, gif.o__grant__valid, gif.o__grant__id, ptr);
        end
    endtask

    // Assert reset between edges, check asynchronously and while held,
    // release just after a negedge so the next posedge is the first active one.
    task automatic do_reset(input string name);
        @(posedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        check_reset({name, "_async"});
        repeat (3) @(negedge clk);
        check_reset({name, "_held"});
        #1;
        reset = 1'b1;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic rdy, input int n);
        req                 = r;
        gif.i__grant__ready = rdy;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog t=%0t: bench did not complete", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        gif.i__grant__ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        #1;
        reset = 1'b1;

        // All ports requesting, full range: ids 0..7 then wrap to 0.
        drive(8'hFF, 1'b1, 12);

        // Grant held while not ready, then 2 -> 5 -> 7 -> 2.
        do_reset("rst_a");
        drive(8'b1010_0100, 1'b0, 4);
        drive(8'b1010_0100, 1'b1, 5);

        // Limit 2: only ports 0..2 participate.
        max_port = 3'd2;
        drive(8'hFF, 1'b1, 8);
        drive(8'hF8, 1'b1, 3);

        // Lower the limit while the pointer is above it.
        do_reset("rst_b");
        max_port = 3'd7;
        drive(8'hFF, 1'b1, 6);
        max_port = 3'd3;
        drive(8'hFF, 1'b1, 6);
        max_port = 3'd7;

        // Idle, single requester, ready while idle.
        drive(8'h00, 1'b1, 3);
        drive(8'h10, 1'b1, 4);
        drive(8'h00, 1'b0, 3);

`ifdef RR_BURST_EN
        do_reset("rst_burst");
        burst_max = 3'd2;
        drive(8'h03, 1'b1, 8);
        do_reset("rst_burst2");
        drive(8'h03, 1'b1, 2);
        drive(8'h02, 1'b1, 4);
        burst_max = 3'd0;
`endif

        // Mid-grant reset with a held grant to port 5.
        drive(8'b0010_0000, 1'b0, 3);
        do_reset("rst_mid");

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if (i % 64 == 0) begin
                max_port = IDW'($urandom_range(0, 7));
`ifdef RR_BURST_EN
                burst_max = BW'($urandom_range(0, 3));
`endif
            end
            if (i == 750) do_reset("rst_rand");
            req = N'($urandom);
            if ($urandom_range(0, 2) == 0) req = req & N'($urandom);
            drive(req, ($urandom_range(0, 3) != 0), 1);
        end

        drive(8'h00, 1'b1, 2);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
